tv_channel_ctrl: RTL and testbench
==================================

# tv_channel_ctrl

Parametrised TV-remote channel selector. Debounces up/down/recall push-buttons and steps a channel register over `NUM_CH` channels, either wrapping or saturating. Adds long-press auto-repeat and a last-channel recall. It drives the channel LEDs directly and sits between the board push-buttons and the display/LED logic of the remote-control design.

## Interface
Parameters:
- `NUM_CH`, 5: number of channels, 2..16; channels are numbered 0..NUM_CH-1.
- `CH_W`, 4: width of the binary channel output; must satisfy 2^CH_W ≥ NUM_CH.
- `DEBOUNCE_CYC`, 5000: consecutive stable cycles required to accept a button level change.
- `HOLD_CYC`, 50000: cycles a debounced press must be held before auto-repeat starts.
- `REPEAT_CYC`, 20000: cycles between auto-repeat steps.
- `WRAP`, 1: 1 = wrap around at the ends; 0 = saturate at 0 and at NUM_CH-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `up`  in  1  raw channel-up button, asynchronous to `clk`, active-high.
- `down`  in  1  raw channel-down button, asynchronous to `clk`, active-high.
- `recall`  in  1  raw last-channel button, asynchronous to `clk`, active-high.
- `ch`  out  CH_W  current channel, binary.
- `led`  out  NUM_CH  one-hot channel indicator; `led[ch]` = 1.
- `changed`  out  1  one-cycle pulse in the cycle after `ch` takes a new value.

## Operation
- Each button passes through a 2-FF synchroniser, then a debounce counter.
  - The debounced level flips once the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles.
  - Any intermediate bounce clears the counter.
- A rising edge of a debounced level produces a one-cycle event. Falling edges produce nothing.
- Auto-repeat applies to up and down only; recall never repeats. Each of up and down has its own FSM:
  - IDLE → HOLD on a debounced rising edge; this same edge produces the first step.
  - HOLD → REPEAT after HOLD_CYC cycles still held; a step is emitted on entry to REPEAT.
  - REPEAT emits a step every REPEAT_CYC cycles.
  - Any state → IDLE on a debounced release; counters clear.
- Event resolution each cycle, in priority order:
  - A recall event swaps `ch` and `prev_ch`.
  - Otherwise, an up step alone gives ch+1.
  - Otherwise, a down step alone gives ch-1.
  - Up and down steps in the same cycle cancel: no change, no `changed` pulse.
- End conditions:
  - WRAP=1: NUM_CH-1 +1 → 0, and 0 −1 → NUM_CH-1.
  - WRAP=0: the step is ignored, `prev_ch` is untouched, and there is no `changed` pulse.
- On every real change, `prev_ch` takes the old `ch`. Recall with `prev_ch == ch` is a no-op with no pulse.
- All arithmetic is in CH_W bits. Wrap is detected by comparing against NUM_CH-1, not by overflow.

## Timing
- Reset values: `ch` = 0, `prev_ch` = 0, `led` = 1 (only `led[0]` set), `changed` = 0. All debounce and repeat FSMs go to IDLE with counters cleared.
- Reset asserted mid-press or mid-repeat aborts immediately. After release, a button still held must be released and pressed again to act.
- Latency: `ch` updates DEBOUNCE_CYC+3 clock edges after the first edge that samples the new raw level (2 synchroniser + DEBOUNCE_CYC debounce + 1 register).
- `led` is registered alongside `ch` and updates in the same cycle.
- `changed` is high for exactly the one cycle after the update.
- First repeat step occurs HOLD_CYC cycles after the press step; subsequent steps follow every REPEAT_CYC cycles.

## Structure
- A shared package `tv_remote_pkg` holds:
  - the repeat-FSM state enum (IDLE, HOLD, REPEAT);
  - a function computing next channel from (ch, dir, NUM_CH, WRAP).
- Sub-module `btn_debounce`:
  - parameter DEBOUNCE_CYC;
  - ports `clk`, `rst`, `din`, `level`, `rise`;
  - instantiated three times.
- Repeat FSMs and channel register live in `tv_channel_ctrl`.

## Test plan
All scenarios use sim parameters DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8, NUM_CH=5 and clk period 10 ns, unless stated otherwise.
- Reset, then up pulsed 5 times (10 cycles high, 30 low each): `ch` goes 1,2,3,4,0; `led` goes 00010…00001; 5 `changed` pulses. Check the DEBOUNCE_CYC+3 edge latency.
- Down pressed once from 0 with WRAP=1: `ch` = 4. Repeat with WRAP=0: `ch` stays 0 and `changed` never asserts.
- Up held 60 cycles from `ch` = 0: steps at press, +20, +28, +36, +44, +52 give `ch` = 1,2,3,4,0,1. Release: no further steps.
- Bounce up (1/0 alternating every 2 cycles for 20 cycles, then low): `ch` unchanged. Then up and down rising in the same cycle: no change, no pulse.
- Sequence up, up, recall, recall: `ch` = 1, 2, 1, 2. Recall immediately after reset: no change.
- Assert `rst` during an up auto-repeat with `ch` = 3: `ch` = 0 and `led` = 00001 asynchronously. Up held through reset release: no step until it is released and pressed again.

Source files
------------

// File: rtl/tv_remote_pkg.sv
// Shared types and helpers for the TV remote-control design.
// Holds the auto-repeat state encoding and channel stepping.
package tv_remote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_e;

  // dir=1 steps up, dir=0 steps down; saturated ends return cur
  function automatic int next_ch(
    input int   cur,
    input logic dir,
    input int   n,
    input bit   wrap
  );
    if (dir) begin
      if (cur == n - 1) return wrap ? 0 : cur;
      return cur + 1;
    end
    if (cur == 0) return wrap ? n - 1 : cur;
    return cur - 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle rise pulse when the debounced level goes high.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (s2 != level)
             && (cnt == CW'(DEBOUNCE_CYC - 1));

  // Synchroniser resets to "pressed" so a button held across
  // reset must be seen released (armed) before it can act.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      armed <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      armed <= armed | ~s2;
      rise  <= flip & s2 & armed;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tv_channel_ctrl.sv
// TV-remote channel selector: debounced up/down/recall buttons,
// long-press auto-repeat, wrap or saturate, last-channel recall.
module tv_channel_ctrl #(
  parameter int NUM_CH       = 5,
  parameter int CH_W         = 4,
  parameter int DEBOUNCE_CYC = 5000,
  parameter int HOLD_CYC     = 50000,
  parameter int REPEAT_CYC   = 20000,
  parameter int WRAP         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up,
  input  logic              down,
  input  logic              recall,
  output logic [CH_W-1:0]   ch,
  output logic [NUM_CH-1:0] led,
  output logic              changed
);

  import tv_remote_pkg::*;

  localparam int RMAX = (HOLD_CYC > REPEAT_CYC)
                      ? HOLD_CYC : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX + 1);
  localparam bit WR   = (WRAP != 0);

  logic [2:0] raw;
  logic [2:0] lvl;
  logic [2:0] rse;

  assign raw = {recall, down, up};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .din   (raw[g]),
      .level (lvl[g]),
      .rise  (rse[g])
    );
  end

  logic unused_lvl;
  assign unused_lvl = lvl[2];

  // Index 0 = up, 1 = down
  rpt_e          st_q  [2];
  rpt_e          st_d  [2];
  logic [RW-1:0] cnt_q [2];
  logic [RW-1:0] cnt_d [2];
  logic [1:0]    step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '{IDLE, IDLE};
      cnt_q <= '{default: '0};
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = '0;
      step[i]  = 1'b0;
      case (st_q[i])
        IDLE: begin
          if (rse[i]) begin
            st_d[i] = HOLD;
            step[i] = 1'b1;
          end
        end
        HOLD: begin
          if (!lvl[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_q[i] == RW'(HOLD_CYC - 1)) begin
            st_d[i] = REPEAT;
            step[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + RW'(1);
          end
        end
        REPEAT: begin
          if (!lvl[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_q[i] == RW'(REPEAT_CYC - 1)) begin
            step[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + RW'(1);
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  logic              up_ev;
  logic              dn_ev;
  logic              rc_ev;
  logic [CH_W-1:0]   prev_ch;
  logic [CH_W-1:0]   tgt;
  logic [CH_W-1:0]   ch_d;
  logic [CH_W-1:0]   prev_d;
  logic [NUM_CH-1:0] led_d;
  logic              chg;

  assign up_ev = step[0];
  assign dn_ev = step[1];
  assign rc_ev = rse[2];

  // Recall is a swap, so every accepted event is "go to tgt"
  always_comb begin
    tgt = ch;
    unique case (1'b1)
      rc_ev:
        tgt = prev_ch;
      !rc_ev && up_ev && !dn_ev:
        tgt = CH_W'(next_ch(int'(ch), 1'b1, NUM_CH, WR));
      !rc_ev && dn_ev && !up_ev:
        tgt = CH_W'(next_ch(int'(ch), 1'b0, NUM_CH, WR));
      default:
        tgt = ch;
    endcase
    ch_d   = ch;
    prev_d = prev_ch;
    chg    = 1'b0;
    if (tgt != ch) begin
      ch_d   = tgt;
      prev_d = ch;
      chg    = 1'b1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      led_d[i] = (ch_d == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch      <= '0;
      prev_ch <= '0;
      led     <= NUM_CH'(1);
      changed <= 1'b0;
    end else begin
      ch      <= ch_d;
      prev_ch <= prev_d;
      led     <= led_d;
      changed <= chg;
    end
  end

endmodule

// File: tb/tb_tv_channel_ctrl.sv
// Scoreboard bench for tv_channel_ctrl (wrapping and saturating).
// Expected channel updates are queued at stimulus time.
module tb_tv_channel_ctrl;

  localparam int NCH = 5;
  localparam int CW  = 4;
  localparam int DB  = 4;
  localparam int HD  = 20;
  localparam int RP  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           up = 1'b0;
  logic           down = 1'b0;
  logic           recall = 1'b0;
  logic           down_s = 1'b0;
  logic [CW-1:0]  ch;
  logic [NCH-1:0] led;
  logic           changed;
  logic [CW-1:0]  ch_s;
  logic [NCH-1:0] led_s;
  logic           changed_s;

  tv_channel_ctrl #(
    .NUM_CH(NCH), .CH_W(CW), .DEBOUNCE_CYC(DB),
    .HOLD_CYC(HD), .REPEAT_CYC(RP), .WRAP(1)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down),
    .recall(recall), .ch(ch), .led(led),
    .changed(changed)
  );

  tv_channel_ctrl #(
    .NUM_CH(NCH), .CH_W(CW), .DEBOUNCE_CYC(DB),
    .HOLD_CYC(HD), .REPEAT_CYC(RP), .WRAP(0)
  ) dut_s (
    .clk(clk), .rst(rst), .up(1'b0), .down(down_s),
    .recall(1'b0), .ch(ch_s), .led(led_s),
    .changed(changed_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   m_ch   = 0;
  int   m_prev = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int mstep(input int c, input bit dir_up);
    if (dir_up) return (c + 1) % NCH;
    return (c + NCH - 1) % NCH;
  endfunction

  task automatic model_ev(input int btn, input int at);
    int n;
    n = (btn == 2) ? m_prev : mstep(m_ch, btn == 0);
    if (n != m_ch) begin
      m_prev = m_ch;
      m_ch   = n;
      sb.push_back(exp_t'{ch: n, cyc: at});
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      0: up = v;
      1: down = v;
      default: recall = v;
    endcase
  endtask

  // Held for hi cycles: press step, then repeats while still held
  task automatic press(input int btn, input int hi, input int lo);
    int c;
    int off;
    @(negedge clk);
    c = cyc;
    set_btn(btn, 1'b1);
    model_ev(btn, c + DB + 3);
    if (btn != 2) begin
      off = HD;
      while (off < hi) begin
        model_ev(btn, c + DB + 3 + off);
        off += RP;
      end
    end
    repeat (hi) @(negedge clk);
    set_btn(btn, 1'b0);
    repeat (lo) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (changed) begin
        if (sb.size() == 0) begin
          chk("extra_changed", 32'(changed), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ch", 32'(ch), mon_e.ch);
          chk("led", 32'(led), 1 << mon_e.ch);
          chk("latency", cyc, mon_e.cyc);
        end
      end
      if (changed_s) chk("sat_changed", 32'(changed_s), 0);
    end
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_led", 32'(led), 1);
    chk("rst_changed", 32'(changed), 0);
    chk("rst_ch_s", 32'(ch_s), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    press(2, 10, 30);
    chk("recall_noop", 32'(ch), 0);

    for (int i = 0; i < 5; i++) press(0, 10, 30);
    chk("up5_ch", 32'(ch), m_ch);

    press(1, 10, 30);
    chk("down_wrap", 32'(ch), 4);

    @(negedge clk);
    down_s = 1'b1;
    repeat (10) @(negedge clk);
    down_s = 1'b0;
    repeat (30) @(negedge clk);
    chk("sat_ch", 32'(ch_s), 0);
    chk("sat_led", 32'(led_s), 1);

    press(0, 10, 30);
    chk("to_zero", 32'(ch), 0);
    press(0, 60, 40);
    chk("held_ch", 32'(ch), 1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); up = 1'b1;
      @(negedge clk);
      @(negedge clk); up = 1'b0;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("bounce_ch", 32'(ch), 1);

    @(negedge clk);
    up = 1'b1;
    down = 1'b1;
    repeat (10) @(negedge clk);
    up = 1'b0;
    down = 1'b0;
    repeat (30) @(negedge clk);
    chk("cancel_ch", 32'(ch), 1);

    press(0, 10, 30);
    press(0, 10, 30);
    press(2, 10, 30);
    chk("recall1", 32'(ch), 2);
    press(2, 10, 30);
    chk("recall2", 32'(ch), 3);

    @(negedge clk);
    c = cyc;
    up = 1'b1;
    model_ev(0, c + DB + 3);
    for (int k = 0; k < 4; k++) begin
      model_ev(0, c + DB + 3 + HD + k * RP);
    end
    repeat (DB + 3 + HD + 3 * RP + 2) @(negedge clk);
    chk("pre_rst_ch", 32'(ch), 3);
    #3 rst = 1'b1;
    #1;
    chk("async_ch", 32'(ch), 0);
    chk("async_led", 32'(led), 1);
    chk("async_changed", 32'(changed), 0);
    m_ch   = 0;
    m_prev = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_thru_rst", 32'(ch), 0);
    up = 1'b0;
    repeat (20) @(negedge clk);
    press(0, 10, 30);
    chk("repress_ch", 32'(ch), 1);

    chk("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
